lbist_core_sequencer: RTL and testbench

LBIST_CORE_SEQUENCER -- requirements
Module: lbist_core_sequencer

---
 rtl/lbist_core_sequencer.sv | 133 +++++++++++++
 tb/tb_lbist_core_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lbist_core_sequencer.sv
// lbist_core_sequencer: sequences logic BIST across NUM_CORES cores, serially or in parallel.
// Latency: test_mode rises the cycle after bist_start; results are registered the cycle after the last core finishes.
// Backpressure: none; bist_start is only honoured in IDLE/DONE, and done bits of untested cores are ignored.
// Ports: clk/rst (sync, active-high); bist_start; core_bist_done/core_go_nogo per core in;
//        fetch_enable_i functional fetch request; core_test_mode/core_fetch_enable per core out;
//        bist_busy, bist_done, go_nogo status; fail_map/timeout_map per-core results.
module lbist_core_sequencer #(
  parameter int unsigned NUM_CORES      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter bit          PARALLEL       = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bist_start,
  input  logic [NUM_CORES-1:0] core_bist_done,
  input  logic [NUM_CORES-1:0] core_go_nogo,
  input  logic                 fetch_enable_i,
  output logic [NUM_CORES-1:0] core_test_mode,
  output logic [NUM_CORES-1:0] core_fetch_enable,
  output logic                 bist_busy,
  output logic                 bist_done,
  output logic                 go_nogo,
  output logic [NUM_CORES-1:0] fail_map,
  output logic [NUM_CORES-1:0] timeout_map
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [TW-1:0]        TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]        TMR_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [IW-1:0]        IDX_LAST = IW'(NUM_CORES - 1);
  localparam logic [NUM_CORES-1:0] ONE_HOT0 = NUM_CORES'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_DONE
  } state_e;

  state_e               state_q;
  logic [TW-1:0]        timer_q;
  logic [IW-1:0]        idx_q;
  logic [NUM_CORES-1:0] test_mode_q;
  logic [NUM_CORES-1:0] fail_q;
  logic [NUM_CORES-1:0] tmo_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 go_q;

  // Next-state helpers for RUN. Masking with test_mode_q both selects the
  // active core(s) and ignores done bits from cores not under test.
  logic [NUM_CORES-1:0] done_vec;
  logic                 expire;
  logic [NUM_CORES-1:0] stuck;
  logic [NUM_CORES-1:0] fail_d;
  logic [NUM_CORES-1:0] tmo_d;
  logic [NUM_CORES-1:0] test_mode_d;

  assign done_vec    = core_bist_done & test_mode_q;
  assign expire      = (timer_q == TMR_LAST);
  // A core finishing on the expiry cycle counts as done, not timed out.
  assign stuck       = expire ? (test_mode_q & ~done_vec) : '0;
  assign fail_d      = fail_q | (done_vec & ~core_go_nogo) | stuck;
  assign tmo_d       = tmo_q | stuck;
  assign test_mode_d = expire ? '0 : (test_mode_q & ~done_vec);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      idx_q       <= '0;
      test_mode_q <= '0;
      fail_q      <= '0;
      tmo_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      go_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bist_start) begin
            state_q     <= S_RUN;
            timer_q     <= '0;
            idx_q       <= '0;
            test_mode_q <= PARALLEL ? '1 : ONE_HOT0;
            fail_q      <= '0;
            tmo_q       <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            go_q        <= 1'b0;
          end
        end
        S_RUN: begin
          fail_q      <= fail_d;
          tmo_q       <= tmo_d;
          test_mode_q <= test_mode_d;
          if (test_mode_d == '0) begin
            timer_q <= '0;
            if (!PARALLEL && (idx_q != IDX_LAST)) begin
              state_q <= S_GAP;
            end else begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              go_q    <= ~|fail_d;
            end
          end else if (timer_q != TMR_MAX) begin
            // Saturate rather than wrap.
            timer_q <= timer_q + TW'(1);
          end
        end
        S_GAP: begin
          state_q     <= S_RUN;
          timer_q     <= '0;
          idx_q       <= idx_q + IW'(1);
          test_mode_q <= ONE_HOT0 << (idx_q + IW'(1));
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_test_mode    = test_mode_q;
  assign core_fetch_enable = {NUM_CORES{fetch_enable_i & ~busy_q}} & ~fail_q;
  assign bist_busy         = busy_q;
  assign bist_done         = done_q;
  assign go_nogo           = go_q;
  assign fail_map          = fail_q;
  assign timeout_map       = tmo_q;

endmodule

// File: tb/tb_lbist_core_sequencer.sv
module tb_lbist_core_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic fe;

  // serial instance (PARALLEL=0)
  logic       s_start;
  logic [3:0] s_done, s_gng, s_tm, s_fe, s_fail, s_tmo;
  logic       s_busy, s_bdone, s_go;

  // parallel instance (PARALLEL=1)
  logic       p_start;
  logic [3:0] p_done, p_gng, p_tm, p_fe, p_fail, p_tmo;
  logic       p_busy, p_bdone, p_go;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lbist_core_sequencer #(.NUM_CORES(4), .TIMEOUT_CYCLES(16), .PARALLEL(1'b0)) u_ser (
    .clk(clk), .rst(rst), .bist_start(s_start),
    .core_bist_done(s_done), .core_go_nogo(s_gng), .fetch_enable_i(fe),
    .core_test_mode(s_tm), .core_fetch_enable(s_fe), .bist_busy(s_busy),
    .bist_done(s_bdone), .go_nogo(s_go), .fail_map(s_fail), .timeout_map(s_tmo)
  );

  lbist_core_sequencer #(.NUM_CORES(4), .TIMEOUT_CYCLES(16), .PARALLEL(1'b1)) u_par (
    .clk(clk), .rst(rst), .bist_start(p_start),
    .core_bist_done(p_done), .core_go_nogo(p_gng), .fetch_enable_i(fe),
    .core_test_mode(p_tm), .core_fetch_enable(p_fe), .bist_busy(p_busy),
    .bist_done(p_bdone), .go_nogo(p_go), .fail_map(p_fail), .timeout_map(p_tmo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called with core i freshly in RUN (timer 0); raises its done after 'at' cycles.
  task automatic ser_core(input int i, input logic pass, input int at);
    logic [3:0] oh;
    oh = 4'b0001 << i;
    chk($sformatf("ser_tm_enter%0d", i), 32'(s_tm), 32'(oh));
    repeat (at) tick();
    s_done[i] = 1'b1;
    s_gng[i]  = pass;
    tick();
    s_done = '0;
    s_gng  = '0;
    chk($sformatf("ser_tm_drop%0d", i), 32'(s_tm), 32'(0));
    if (i < 3) begin
      chk($sformatf("ser_gap_busy%0d", i), 32'(s_busy), 32'(1));
      tick();
    end
  endtask

  logic [3:0] par_exp [8];
  int         par_dt  [4];
  int         cnt;

  initial begin
    par_exp = '{4'b1111, 4'b1111, 4'b1111, 4'b1110, 4'b1110, 4'b1000, 4'b1000, 4'b0000};
    par_dt  = '{3, 5, 5, 7};

    rst = 1'b1; fe = 1'b1;
    s_start = 1'b0; s_done = '0; s_gng = '0;
    p_start = 1'b0; p_done = '0; p_gng = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // reset state
    chk("rst_s_tm",    32'(s_tm),    32'(0));
    chk("rst_s_busy",  32'(s_busy),  32'(0));
    chk("rst_s_bdone", 32'(s_bdone), 32'(0));
    chk("rst_s_go",    32'(s_go),    32'(0));
    chk("rst_s_fail",  32'(s_fail),  32'(0));
    chk("rst_s_tmo",   32'(s_tmo),   32'(0));
    chk("rst_s_fe",    32'(s_fe),    32'hF);
    chk("rst_p_tm",    32'(p_tm),    32'(0));
    chk("rst_p_fe",    32'(p_fe),    32'hF);

    // serial, core 2 fails
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    chk("a_busy", 32'(s_busy), 32'(1));
    chk("a_fe_busy", 32'(s_fe), 32'(0));
    ser_core(0, 1'b1, 2);
    ser_core(1, 1'b1, 2);
    ser_core(2, 1'b0, 2);
    ser_core(3, 1'b1, 2);
    chk("a_bdone", 32'(s_bdone), 32'(1));
    chk("a_busy_end", 32'(s_busy), 32'(0));
    chk("a_go", 32'(s_go), 32'(0));
    chk("a_fail", 32'(s_fail), 32'b0100);
    chk("a_tmo", 32'(s_tmo), 32'(0));
    chk("a_fe", 32'(s_fe), 32'b1011);
    tick();
    chk("a_bdone_hold", 32'(s_bdone), 32'(1));

    // serial, core 1 times out, core 2 done on the last timer value
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    chk("b_fail_clr", 32'(s_fail), 32'(0));
    chk("b_bdone_clr", 32'(s_bdone), 32'(0));
    ser_core(0, 1'b1, 1);
    cnt = 0;
    while (s_tm == 4'b0010 && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("b_tmo_window", 32'(cnt), 32'(16));
    chk("b_tmo_map", 32'(s_tmo), 32'b0010);
    chk("b_fail_map", 32'(s_fail), 32'b0010);
    tick();
    ser_core(2, 1'b1, 15);
    chk("b_edge_tmo", 32'(s_tmo), 32'b0010);
    ser_core(3, 1'b1, 0);
    chk("b_fail_end", 32'(s_fail), 32'b0010);
    chk("b_tmo_end", 32'(s_tmo), 32'b0010);
    chk("b_go", 32'(s_go), 32'(0));
    chk("b_bdone", 32'(s_bdone), 32'(1));
    chk("b_fe", 32'(s_fe), 32'b1101);

    // parallel, done at RUN cycles 3,5,5,7 (done bits left high afterwards)
    p_gng = 4'b1111;
    p_start = 1'b1;
    tick();
    p_start = 1'b0;
    chk("c_tm_start", 32'(p_tm), 32'hF);
    chk("c_busy", 32'(p_busy), 32'(1));
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 4; i++)
        if (par_dt[i] == t) p_done[i] = 1'b1;
      tick();
      chk($sformatf("c_tm_t%0d", t), 32'(p_tm), 32'(par_exp[t]));
      chk($sformatf("c_bdone_t%0d", t), 32'(p_bdone), (t == 7) ? 32'(1) : 32'(0));
    end
    p_done = '0;
    chk("c_go", 32'(p_go), 32'(1));
    chk("c_busy_end", 32'(p_busy), 32'(0));
    chk("c_fail", 32'(p_fail), 32'(0));
    chk("c_tmo", 32'(p_tmo), 32'(0));

    // serial, bist_start during RUN is ignored; then rst mid-RUN
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    cnt = 0;
    while (s_tm == 4'b0001 && cnt < 40) begin
      s_start = (cnt == 2);
      cnt++;
      tick();
    end
    s_start = 1'b0;
    chk("d_no_restart", 32'(cnt), 32'(16));
    chk("d_tmo", 32'(s_tmo), 32'b0001);
    repeat (3) tick();
    chk("d_run_core1", 32'(s_tm), 32'b0010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("d_rst_tm", 32'(s_tm), 32'(0));
    chk("d_rst_busy", 32'(s_busy), 32'(0));
    chk("d_rst_bdone", 32'(s_bdone), 32'(0));
    chk("d_rst_go", 32'(s_go), 32'(0));
    chk("d_rst_fail", 32'(s_fail), 32'(0));
    chk("d_rst_tmo", 32'(s_tmo), 32'(0));
    chk("d_rst_fe", 32'(s_fe), 32'hF);
    rst = 1'b1;
    s_start = 1'b1;
    tick();
    rst = 1'b0;
    s_start = 1'b0;
    chk("d_rst_prio", 32'(s_busy), 32'(0));
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    chk("d_restart", 32'(s_tm), 32'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1);
  end

endmodule
